// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock first-word-fall-through FIFO with exact fill level,
//   programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Latency: a word pushed at edge N is visible on data_o after edge N; status flags come from registers only.
// Backpressure: a push while full is accepted only together with a pop; other pushes while full
//   are dropped and set overflow_o. A pop while empty is dropped and sets underflow_o.
//
// Ports:
//   clk_i, arstn_i              clock, asynchronous active-low reset
//   data_i, push_i              write data / write request
//   pop_i                       read request, acknowledges the current data_o
//   data_o                      head word (mem[rd_ptr]), meaningful while empty_o=0
//   full_o, empty_o             level == FIFO_DEPTH / level == 0
//   almost_full_o               level >= afull_thr_i
//   almost_empty_o              level <= aempty_thr_i
//   afull_thr_i, aempty_thr_i   quasi-static thresholds, sampled continuously
//   level_o                     current word count, 0..FIFO_DEPTH
//   overflow_o, underflow_o     sticky error flags
//   clear_err_i                 synchronous clear of the error flags (a new error in the same cycle wins)
//   flush_i                     present only when SYNC_FIFO_LVL_FLUSH_EN is defined: empties the FIFO
//
// Optional feature macro: SYNC_FIFO_LVL_FLUSH_EN

module sync_fifo_lvl #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic [FIFO_WIDTH-1:0] data_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [FIFO_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  input  logic [LVL_WIDTH-1:0]  afull_thr_i,
  input  logic [LVL_WIDTH-1:0]  aempty_thr_i,
  output logic [LVL_WIDTH-1:0]  level_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
`ifdef SYNC_FIFO_LVL_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  clear_err_i
);

  localparam int                   PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_WIDTH-1:0] LVL_MAX  = LVL_WIDTH'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_WIDTH-1:0]  level;
  logic                  overflow;
  logic                  underflow;

  logic                  full;
  logic                  empty;
  logic                  flush;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  err_clr;

`ifdef SYNC_FIFO_LVL_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Status decodes look only at the level register, so they never glitch on push/pop.
  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);

  // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
  // Flush overrides both requests.
  assign push_acc = push_i & (~full | pop_i) & ~flush;
  assign pop_acc  = pop_i & ~empty & ~flush;

  // Flush leaves the error flags completely untouched, including clear.
  assign ovf_set = push_i & full & ~pop_i & ~flush;
  assign unf_set = pop_i & empty & ~flush;
  assign err_clr = clear_err_i & ~flush;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_acc, pop_acc})
        2'b10:   level <= level + LVL_WIDTH'(1);
        2'b01:   level <= level - LVL_WIDTH'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

  // Storage has no reset; contents are only observable once written.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr] <= data_i;
  end

  assign data_o         = mem[rd_ptr];
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (level >= afull_thr_i);
  assign almost_empty_o = (level <= aempty_thr_i);
  assign level_o        = level;
  assign overflow_o     = overflow;
  assign underflow_o    = underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: self-checking bench for sync_fifo_lvl (WIDTH=16, DEPTH=6).
// A queue-based model tracks contents and sticky flags; every cycle the DUT outputs
// are compared against it, and directed steps add literal expectations.

module tb_sync_fifo_lvl;

  localparam int W = 16;
  localparam int D = 6;
  localparam int L = $clog2(D + 1);

  logic         clk_i = 1'b0;
  logic         arstn_i;
  logic [W-1:0] data_i;
  logic         push_i;
  logic         pop_i;
  logic [W-1:0] data_o;
  logic         full_o;
  logic         empty_o;
  logic         almost_full_o;
  logic         almost_empty_o;
  logic [L-1:0] afull_thr_i;
  logic [L-1:0] aempty_thr_i;
  logic [L-1:0] level_o;
  logic         overflow_o;
  logic         underflow_o;
  logic         clear_err_i;
`ifdef SYNC_FIFO_LVL_FLUSH_EN
  logic         flush_i;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [W-1:0] mq[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  sync_fifo_lvl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .data_i         (data_i),
    .push_i         (push_i),
    .pop_i          (pop_i),
    .data_o         (data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .afull_thr_i    (afull_thr_i),
    .aempty_thr_i   (aempty_thr_i),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
`ifdef SYNC_FIFO_LVL_FLUSH_EN
    .flush_i        (flush_i),
`endif
    .clear_err_i    (clear_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the edge, then compare once outputs have settled.
  always @(posedge clk_i) begin
    bit full, empty, flush_now;
    full  = (mq.size() == D);
    empty = (mq.size() == 0);
    flush_now = 1'b0;
`ifdef SYNC_FIFO_LVL_FLUSH_EN
    flush_now = (flush_i === 1'b1);
`endif
    if (arstn_i !== 1'b1) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush_now) begin
      mq.delete();
    end else begin
      if (clear_err_i) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (push_i && full && !pop_i) m_ovf = 1'b1;
      if (pop_i && empty)           m_unf = 1'b1;
      if (pop_i && !empty)          void'(mq.pop_front());
      if (push_i && (!full || pop_i)) mq.push_back(data_i);
    end
    #1;
    check("level",        32'(level_o),        32'(mq.size()));
    check("empty",        32'(empty_o),        32'(mq.size() == 0));
    check("full",         32'(full_o),         32'(mq.size() == D));
    check("almost_full",  32'(almost_full_o),  32'(mq.size() >= int'(afull_thr_i)));
    check("almost_empty", 32'(almost_empty_o), 32'(mq.size() <= int'(aempty_thr_i)));
    check("overflow",     32'(overflow_o),     32'(m_ovf));
    check("underflow",    32'(underflow_o),    32'(m_unf));
    if (mq.size() != 0) check("data", 32'(data_o), 32'(mq[0]));
  end

  // Drive one cycle's inputs at a falling edge and return at the next falling edge.
  task automatic cycle(input bit p, input bit q, input logic [W-1:0] d, input bit c);
    push_i      = p;
    pop_i       = q;
    data_i      = d;
    clear_err_i = c;
`ifdef SYNC_FIFO_LVL_FLUSH_EN
    flush_i     = 1'b0;
`endif
    @(negedge clk_i);
    push_i      = 1'b0;
    pop_i       = 1'b0;
    clear_err_i = 1'b0;
  endtask

`ifdef SYNC_FIFO_LVL_FLUSH_EN
  task automatic flush_cycle(input bit p, input logic [W-1:0] d);
    push_i  = p;
    pop_i   = 1'b0;
    data_i  = d;
    flush_i = 1'b1;
    @(negedge clk_i);
    push_i  = 1'b0;
    flush_i = 1'b0;
  endtask
`endif

  initial begin
    arstn_i      = 1'b0;
    push_i       = 1'b0;
    pop_i        = 1'b0;
    data_i       = '0;
    clear_err_i  = 1'b0;
    afull_thr_i  = L'(5);
    aempty_thr_i = L'(1);
`ifdef SYNC_FIFO_LVL_FLUSH_EN
    flush_i      = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;

    // Reset / idle
    cycle(0, 0, '0, 0);
    check("rst_level", 32'(level_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_aempty", 32'(almost_empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_ovf_unf", {30'd0, overflow_o, underflow_o}, 0);

    // FWFT first word
    cycle(1, 0, 16'hA001, 0);
    check("fwft_empty", 32'(empty_o), 0);
    check("fwft_data", 32'(data_o), 32'hA001);
    check("fwft_level", 32'(level_o), 1);
    check("fwft_aempty", 32'(almost_empty_o), 1);
    cycle(1, 0, 16'hA002, 0);
    check("lvl2", 32'(level_o), 2);
    check("lvl2_aempty", 32'(almost_empty_o), 0);
    cycle(0, 1, '0, 0);
    check("pop_next", 32'(data_o), 32'hA002);
    cycle(0, 1, '0, 0);

    // Fill to full, then overflow
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 0, W'(i), 0);
      if (i == 4) check("afull_at4", 32'(almost_full_o), 0);
      if (i == 5) check("afull_at5", 32'(almost_full_o), 1);
      if (i == 5) check("full_at5", 32'(full_o), 0);
      if (i == 6) check("full_at6", 32'(full_o), 1);
    end
    cycle(1, 0, 16'h0007, 0);
    check("ovf_level", 32'(level_o), 6);
    check("ovf_flag", 32'(overflow_o), 1);
    for (int i = 1; i <= 6; i++) begin
      check("drain_order", 32'(data_o), 32'(i));
      cycle(0, 1, '0, 0);
    end
    check("drained_empty", 32'(empty_o), 1);
    cycle(0, 0, '0, 1);
    check("ovf_cleared", 32'(overflow_o), 0);

    // Full with simultaneous push+pop, wrapping twice
    for (int i = 1; i <= 6; i++) cycle(1, 0, W'(i), 0);
    cycle(1, 1, 16'h00AA, 0);
    check("pp_full_level", 32'(level_o), 6);
    check("pp_full_ovf", 32'(overflow_o), 0);
    check("pp_full_data", 32'(data_o), 32'h0002);
    for (int k = 0; k < 12; k++) cycle(1, 1, W'(16'h0100 + k), 0);
    check("wrap_head", 32'(data_o), 32'h0106);
    for (int i = 0; i < 6; i++) begin
      check("wrap_order", 32'(data_o), 32'(16'h0106 + i));
      cycle(0, 1, '0, 0);
    end

    // Empty with simultaneous push+pop
    cycle(1, 1, 16'h00BB, 0);
    check("pp_empty_unf", 32'(underflow_o), 1);
    check("pp_empty_level", 32'(level_o), 1);
    check("pp_empty_data", 32'(data_o), 32'h00BB);
    cycle(0, 0, '0, 1);
    check("clr_flags", {30'd0, overflow_o, underflow_o}, 0);

    // Set wins over clear
    cycle(0, 1, '0, 0);
    cycle(0, 1, '0, 1);
    check("unf_set_wins", 32'(underflow_o), 1);
    cycle(0, 0, '0, 1);
    check("unf_clr", 32'(underflow_o), 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, W'(16'h0200 + i), 0);
    cycle(1, 0, 16'h0300, 1);
    check("ovf_set_wins", 32'(overflow_o), 1);
    cycle(0, 0, '0, 1);

    // Threshold changes take effect without a clock edge
    afull_thr_i = L'(7);
    #1 check("thr_afull7", 32'(almost_full_o), 0);
    aempty_thr_i = L'(6);
    #1 check("thr_aempty6", 32'(almost_empty_o), 1);
    cycle(0, 1, '0, 0);
    afull_thr_i  = L'(5);
    aempty_thr_i = L'(1);
    #1 check("thr_restore_afull", 32'(almost_full_o), 1);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) cycle(0, 1, '0, 0);
    check("final_empty", 32'(empty_o), 1);

`ifdef SYNC_FIFO_LVL_FLUSH_EN
    for (int i = 0; i < 4; i++) cycle(1, 0, W'(16'h0D00 + i), 0);
    flush_cycle(1, 16'h0EEE);
    check("flush_level", 32'(level_o), 0);
    check("flush_empty", 32'(empty_o), 1);
    cycle(1, 0, 16'h00CC, 0);
    check("post_flush_data", 32'(data_o), 32'h00CC);
    check("post_flush_level", 32'(level_o), 1);
    cycle(0, 1, '0, 0);
`endif

    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
Next-generation synchronous FIFO for single-clock datapaths. It is first-word-fall-through and parametrised in width and depth, with any depth ≥ 2 supported (power of two not required). Adds an exact fill-level output, runtime-programmable almost-full/almost-empty thresholds, push/pop protection and sticky overflow/underflow error flags. Used as the general buffering primitive between streaming stages and register-mapped peripherals.

Parameters:
FIFO_WIDTH, 32, data word width in bits (≥1)
FIFO_DEPTH, 64, number of storage words (≥2, any integer)
LVL_WIDTH, $clog2(FIFO_DEPTH+1), width of level/threshold ports (derived, do not override)

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
data_i  in  FIFO_WIDTH  write data
push_i  in  1  write request
pop_i  in  1  read request (acknowledges current data_o)
data_o  out  FIFO_WIDTH  head word, valid while empty_o=0
full_o  out  1  level == FIFO_DEPTH
empty_o  out  1  level == 0
almost_full_o  out  1  level >= afull_thr_i
almost_empty_o  out  1  level <= aempty_thr_i
afull_thr_i  in  LVL_WIDTH  almost-full threshold, quasi-static
aempty_thr_i  in  LVL_WIDTH  almost-empty threshold, quasi-static
level_o  out  LVL_WIDTH  current word count, 0..FIFO_DEPTH
overflow_o  out  1  sticky: push rejected while full
underflow_o  out  1  sticky: pop rejected while empty
clear_err_i  in  1  synchronous clear of overflow_o/underflow_o

Behaviour:
- Reset: clk_i, arstn_i asynchronous active-low. wr_ptr=rd_ptr=0, level_o=0, empty_o=1, full_o=0, almost_empty_o=(0<=aempty_thr_i), almost_full_o=(0>=afull_thr_i), overflow_o=underflow_o=0. data_o is don't-care while empty.
- Accept rules: push_acc = push_i & (~full_o | pop_i). pop_acc = pop_i & ~empty_o.
- Rejected pushes and pops do not move pointers or level and do not modify storage.
- Full with push_i&pop_i: both accepted, level unchanged.
- Empty with push_i&pop_i: push accepted, pop rejected, underflow_o set.
- Pointers: wr_ptr/rd_ptr in 0..FIFO_DEPTH-1, increment on accept, wrap from FIFO_DEPTH-1 to 0 (explicit compare, not a power-of-two modulo).
- Level: registered counter. +1 on push_acc only, -1 on pop_acc only, unchanged on both or neither. Never exceeds FIFO_DEPTH, never underflows.
- FWFT latency: a push into an empty FIFO at edge N gives empty_o=0 and data_o=that word after edge N. data_o always shows mem[rd_ptr].
- After a pop_acc at edge N, data_o shows the next word after edge N.
- Storage: registered writes. Reads are combinational from mem[rd_ptr] (distributed RAM/flops).
- Flags: full_o, empty_o, almost_* are combinational decodes of the level register only (glitch-free, no combinational path from push_i/pop_i).
- Threshold ports are sampled continuously. Changing them updates almost_* in the same cycle.
- Errors: overflow_o set on push_i & full_o & ~pop_i. underflow_o set on pop_i & empty_o.
  - Both flags hold until clear_err_i.
  - If clear_err_i and a new error occur in the same cycle, set wins.

Optional Feature:
Macro SYNC_FIFO_LVL_FLUSH_EN.
- Defined: adds input port flush_i (1 bit). When flush_i=1 at a clock edge, the following happen after that edge:
  - wr_ptr=rd_ptr=0, level_o=0, empty_o=1.
  - Error flags are unaffected.
  - flush_i overrides push_i/pop_i that cycle: no write, no error flag update.
- Not defined: port absent, no flush logic.

Test Plan:
WIDTH=16, DEPTH=6 (non-power-of-two), afull_thr_i=5, aempty_thr_i=1.
- Reset, then idle -> level_o=0, empty_o=1, almost_empty_o=1, full_o=0, overflow_o=underflow_o=0.
- Push 0xA001 once -> next cycle empty_o=0, data_o=0xA001, level_o=1, almost_empty_o=1.
  - Push 0xA002 -> level_o=2, almost_empty_o=0.
- Push 0x0001..0x0006 -> level_o=6, full_o=1, almost_full_o=1 from level 5.
  - 7th push 0x0007 -> level unchanged, overflow_o=1.
  - Pop x6 returns 0x0001..0x0006 in order.
- Fill to 6, then push 0x00AA and pop together -> level_o=6, no overflow, data_o=0x0002.
  - Repeat for 12 cycles (wrap twice) -> data order intact.
- Empty FIFO, push 0x00BB and pop together -> underflow_o=1, level_o=1, data_o=0x00BB.
  - clear_err_i pulse -> both flags 0.
- With SYNC_FIFO_LVL_FLUSH_EN: fill to 4, assert flush_i with push_i=1 -> level_o=0, empty_o=1.
  - Next push 0x00CC -> data_o=0x00CC, level_o=1.
